// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB master. A valid/ready command port is turned into an
// APB SETUP/ACCESS transfer to one of two slaves, and the result comes back on
// a one-cycle response strobe.
//
// Command handshake: a command transfers at a PCLK edge where cmd_valid and
// cmd_ready are both 1; the command fields are sampled only at that edge.
// cmd_ready is combinational (1 in IDLE, or in ACCESS when the selected slave
// is completing) and is 0 while PRESET is high. rsp_valid is a one-cycle
// strobe with no back-pressure.
//
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT
// cycles without PREADY (reported with rsp_err = 1). Without it rsp_err is 0
// and ACCESS waits indefinitely.
//
// Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   cmd_valid/ready/write/sel/addr/wdata   command port
//   rsp_valid, rsp_rdata, rsp_err         response port
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA   APB request (registered)
//   PREADY1/2, PRDATA1/2      APB completion from slave 1 / slave 2
//   state_dbg                 current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// ----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY1,
    input  logic              PREADY2,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

    // Only the selected slave is observed; PSEL2 doubles as the select memory
    // because exactly one PSEL is high throughout SETUP and ACCESS.
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;

    assign sel_ready = PSEL2 ? PREADY2 : PREADY1;
    assign sel_rdata = PSEL2 ? PRDATA2 : PRDATA1;
    assign cmd_ready = !PRESET &&
                       ((state == IDLE) || ((state == ACCESS) && sel_ready));
    assign state_dbg = state;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;

    // A completing PREADY on the same edge always wins over the timeout.
    assign timeout_hit = (state == ACCESS) && !sel_ready &&
                         (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET || state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    PENABLE <= 1'b0;
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PSEL1  <= !cmd_sel;
                        PSEL2  <= cmd_sel;
                        state  <= SETUP;
                    end else begin
                        PSEL1 <= 1'b0;
                        PSEL2 <= 1'b0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        if (!PWRITE) begin
                            rsp_rdata <= sel_rdata;
                        end
                        PENABLE <= 1'b0;
                        // Back-to-back: next command goes straight to SETUP.
                        if (cmd_valid) begin
                            PWRITE <= cmd_write;
                            PADDR  <= cmd_addr;
                            PWDATA <= cmd_wdata;
                            PSEL1  <= !cmd_sel;
                            PSEL2  <= cmd_sel;
                            state  <= SETUP;
                        end else begin
                            PSEL1 <= 1'b0;
                            PSEL2 <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        PENABLE   <= 1'b0;
                        PSEL1     <= 1'b0;
                        PSEL2     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
